uart_tx_frame_arbiter: RTL and testbench
========================================

UART_TX_FRAME_ARBITER -- requirements
Module: uart_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter SOF_BYTE, default 8'hAA, start-of-frame byte.
REQ-002 SHALL have parameter ID0, default 8'h00, source-ID byte for requester 0.
REQ-003 SHALL have parameter ID1, default 8'h01, source-ID byte for requester 1.
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports s0_data / s1_data  input  8  payload byte from requester 0 / 1.
REQ-007 SHALL have ports s0_valid / s1_valid  input  1  payload byte valid; a valid in IDLE is a frame request.
REQ-008 SHALL have ports s0_last / s1_last  input  1  marks final payload byte of the frame.
REQ-009 SHALL have ports s0_ready / s1_ready  output  1  byte accepted this cycle.
REQ-010 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-011 SHALL have port tx_start  output  1  one-cycle transmit strobe.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-013 SHALL have port grant  output  2  one-hot owner of current frame; 2'b00 when idle.
REQ-014 SHALL have port frame_active  output  1  high from grant until last frame byte finishes.

Function
REQ-015 Frame SHALL be: SOF_BYTE, ID byte of granted source, payload bytes in order, then optional checksum (REQ-031).
REQ-016 Top FSM states SHALL be IDLE, SOF, ID, PAY, CSUM; each non-IDLE state sends one byte via the byte sub-FSM ISSUE -> WAIT_HI -> WAIT_LO.
REQ-017 ISSUE SHALL drive tx_start=1 for exactly one cycle, with tx_data valid, only when tx_busy=0; otherwise stay in ISSUE.
REQ-018 WAIT_HI SHALL hold until tx_busy=1; WAIT_LO SHALL hold until tx_busy=0, then the byte is done.
REQ-019 tx_data SHALL remain stable from ISSUE until byte done.
REQ-020 IDLE with exactly one sN_valid=1 SHALL grant that source and enter SOF next cycle.
REQ-021 IDLE with both valid SHALL grant the source not served by the previous frame (round-robin).
REQ-022 SOF done -> ID; ID done -> PAY.
REQ-023 In PAY ISSUE, sN_ready SHALL be asserted in the same cycle as tx_start, and only when the granted sN_valid=1 and tx_busy=0; stall otherwise, with no timeout.
REQ-024 The non-granted source's ready SHALL stay 0 for the whole frame; its valid and data SHALL be ignored.
REQ-025 Payload byte accepted with last=0 -> next PAY byte; last=1 -> CSUM if enabled, else IDLE, after byte done.
REQ-026 On return to IDLE, grant SHALL be 2'b00 and frame_active 0, with at least one IDLE cycle between frames.
REQ-027 A zero-length payload is impossible: the first accepted payload byte is always sent.
REQ-028 Latency: valid in IDLE at cycle t -> first tx_start (SOF) at cycle t+2 when tx_busy=0.

Reset
REQ-029 On reset_n=0, asynchronously: FSM to IDLE; tx_start, s0_ready, s1_ready, frame_active to 0; grant 2'b00; tx_data 8'h00; checksum 0; round-robin pointer to "last served = 1", so source 0 wins the first tie.
REQ-030 Reset mid-frame SHALL abandon the frame; after release no byte of it is resent.

Configuration
REQ-031 Macro UART_ARB_CHECKSUM_EN defined: CSUM state SHALL send XOR of ID byte and all payload bytes after the last payload byte.
REQ-032 UART_ARB_CHECKSUM_EN undefined: no CSUM state and no checksum register; frame ends after last payload byte.

Verification
REQ-033 s0 sends 8'h12, 8'h34 (last), tx_busy model 10 cycles/byte -> tx bytes AA,00,12,34[,26 with checksum]; s1_ready never high.
REQ-034 s0 and s1 valid together after reset -> s0 frame completes first, then s1 frame with ID 01; next tie goes to s0.
REQ-035 s1 payload valid dropped for 20 cycles mid-frame -> no tx_start during gap; frame resumes; byte order preserved.
REQ-036 tx_busy held high 50 cycles at SOF issue -> tx_start stays 0 until busy falls, then exactly one pulse.
REQ-037 reset_n pulsed low during PAY -> outputs at reset values immediately; after release IDLE, no residual bytes sent.
REQ-038 Single byte 8'hFF with last=1 from s1 -> AA,01,FF[,FE]; grant returns to 2'b00.

Source files
------------

// File: rtl/uart_tx_frame_arbiter_if.sv
// Handshake bundle between two payload requesters, the frame arbiter and a byte-wide UART transmitter.
interface uart_tx_frame_arbiter_if;
   logic [7:0] s0_data;
   logic       s0_valid;
   logic       s0_last;
   logic       s0_ready;
   logic [7:0] s1_data;
   logic       s1_valid;
   logic       s1_last;
   logic       s1_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic [1:0] grant;
   logic       frame_active;

   modport slave (
      input  s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last, tx_busy,
      output s0_ready, s1_ready, tx_data, tx_start, grant, frame_active
   );

   modport master (
      output s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last, tx_busy,
      input  s0_ready, s1_ready, tx_data, tx_start, grant, frame_active
   );
endinterface

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin framer for two requesters: SOF, source ID, payload, optional XOR checksum.
// Define UART_ARB_CHECKSUM_EN to append the checksum byte after the payload.
module uart_tx_frame_arbiter #(
   parameter logic [7:0] SOF_BYTE = 8'hAA,
   parameter logic [7:0] ID0      = 8'h00,
   parameter logic [7:0] ID1      = 8'h01
) (
   input logic                    clk,
   input logic                    reset_n,
   uart_tx_frame_arbiter_if.slave bus
);

`ifdef UART_ARB_CHECKSUM_EN
   typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_ID, ST_PAY, ST_CSUM} frame_state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_ID, ST_PAY} frame_state_t;
`endif
   typedef enum logic [1:0] {BY_ISSUE, BY_WAIT_HI, BY_WAIT_LO} byte_state_t;

   frame_state_t state;
   frame_state_t state_after;
   byte_state_t  byte_st;
   logic         owner;
   logic         last_served;
   logic         pay_last;
   logic         pick;
   logic         own_valid;
   logic         own_last;
   logic [7:0]   own_data;
   logic [7:0]   own_id;
   logic [7:0]   issue_byte;
`ifdef UART_ARB_CHECKSUM_EN
   logic [7:0]   csum;
`endif

   assign own_valid = owner ? bus.s1_valid : bus.s0_valid;
   assign own_last  = owner ? bus.s1_last  : bus.s0_last;
   assign own_data  = owner ? bus.s1_data  : bus.s0_data;
   assign own_id    = owner ? ID1 : ID0;
   // A tie goes to the source that did not own the previous frame.
   assign pick = (bus.s0_valid && bus.s1_valid) ? ~last_served : bus.s1_valid;

   always_comb begin
      // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
      issue_byte  = own_data;
      state_after = ST_IDLE;
      case (state)
         ST_SOF: begin
            issue_byte  = SOF_BYTE;
            state_after = ST_ID;
         end
         ST_ID: begin
            issue_byte  = own_id;
            state_after = ST_PAY;
         end
         ST_PAY: begin
`ifdef UART_ARB_CHECKSUM_EN
            state_after = pay_last ? ST_CSUM : ST_PAY;
`else
            state_after = pay_last ? ST_IDLE : ST_PAY;
`endif
         end
`ifdef UART_ARB_CHECKSUM_EN
         ST_CSUM: begin
            issue_byte  = csum;
            state_after = ST_IDLE;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= ST_IDLE;
         byte_st          <= BY_ISSUE;
         owner            <= 1'b0;
         last_served      <= 1'b1;
         pay_last         <= 1'b0;
         bus.tx_start     <= 1'b0;
         bus.tx_data      <= 8'h00;
         bus.s0_ready     <= 1'b0;
         bus.s1_ready     <= 1'b0;
         bus.grant        <= 2'b00;
         bus.frame_active <= 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
         csum             <= 8'h00;
`endif
      end else begin
         // NOTE: non-blocking throughout; strobes default low so each pulse lasts one cycle.
         bus.tx_start <= 1'b0;
         bus.s0_ready <= 1'b0;
         bus.s1_ready <= 1'b0;
         if (state == ST_IDLE) begin
            if (bus.s0_valid || bus.s1_valid) begin
               owner            <= pick;
               last_served      <= pick;
               bus.grant        <= pick ? 2'b10 : 2'b01;
               bus.frame_active <= 1'b1;
               pay_last         <= 1'b0;
               state            <= ST_SOF;
               byte_st          <= BY_ISSUE;
`ifdef UART_ARB_CHECKSUM_EN
               csum             <= pick ? ID1 : ID0;
`endif
            end
         end else begin
            case (byte_st)
               BY_ISSUE: begin
                  // Payload bytes wait for the owner's valid; header bytes only for the transmitter.
                  if (!bus.tx_busy && (state != ST_PAY || own_valid)) begin
                     bus.tx_start <= 1'b1;
                     bus.tx_data  <= issue_byte;
                     byte_st      <= BY_WAIT_HI;
                     if (state == ST_PAY) begin
                        bus.s0_ready <= ~owner;
                        bus.s1_ready <= owner;
                        pay_last     <= own_last;
`ifdef UART_ARB_CHECKSUM_EN
                        csum         <= csum ^ own_data;
`endif
                     end
                  end
               end
               BY_WAIT_HI: if (bus.tx_busy) byte_st <= BY_WAIT_LO;
               BY_WAIT_LO: begin
                  if (!bus.tx_busy) begin
                     byte_st <= BY_ISSUE;
                     state   <= state_after;
                     if (state_after == ST_IDLE) begin
                        bus.grant        <= 2'b00;
                        bus.frame_active <= 1'b0;
                     end
                  end
               end
               default: byte_st <= BY_ISSUE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Bench for uart_tx_frame_arbiter: table vectors, hand-written corner sequences and random frames vs a frame-level model.
`timescale 1ns/1ps
module tb_uart_tx_frame_arbiter;
   localparam logic [7:0] SOF = 8'hAA;
   localparam logic [7:0] ID0 = 8'h00;
   localparam logic [7:0] ID1 = 8'h01;
`ifdef UART_ARB_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } item_t;

   // Byte lists are packed: the rightmost byte of each concatenation is element 0.
   typedef struct packed {
      logic            src;
      logic [2:0]      len;
      logic [3:0][7:0] pay;
      logic [2:0]      exp_len;
      logic [5:0][7:0] exp;
      logic [7:0]      cs;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   uart_tx_frame_arbiter_if bus();

   uart_tx_frame_arbiter #(.SOF_BYTE(SOF), .ID0(ID0), .ID1(ID1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   item_t      q0[$];
   item_t      q1[$];
   logic [7:0] got[$];
   int         start_cyc[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         last_start_cyc = 0;
   int         busy_cnt = 0;
   int         busy_len = 10;
   int         gap0 = 0, gap1 = 0, gap_len0 = 0, gap_len1 = 0;
   bit         busy_hold = 1'b0;
   bit         prev_start = 1'b0;
   bit         rr_last = 1'b1;
   logic [1:0] prev_grant = 2'b00;
   logic [7:0] held = 8'h00;
   int         pulse_err, busy_err, ready_err, stab_err, gap_err, idle_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF;
   endfunction

   // One clock: observe outputs at the falling edge, then advance transmitter and requester models.
   task automatic step();
      item_t it;
      @(negedge clk);
      cyc++;
      if (bus.tx_start) begin
         got.push_back(bus.tx_data);
         start_cyc.push_back(cyc);
         last_start_cyc = cyc;
         held = bus.tx_data;
         if (prev_start) pulse_err++;
         if (bus.tx_busy) busy_err++;
         if (gap0 > 0 || gap1 > 0) gap_err++;
      end
      prev_start = bus.tx_start;
      if (busy_cnt > 0 && bus.tx_data !== held) stab_err++;
      if (bus.s0_ready && (bus.grant != 2'b01 || !bus.tx_start)) ready_err++;
      if (bus.s1_ready && (bus.grant != 2'b10 || !bus.tx_start)) ready_err++;
      if (bus.frame_active != (bus.grant != 2'b00)) idle_err++;
      if (prev_grant != 2'b00 && bus.grant != 2'b00 && bus.grant != prev_grant) idle_err++;
      prev_grant = bus.grant;
      if (gap0 > 0) gap0--;
      if (gap1 > 0) gap1--;
      if (bus.s0_ready) begin
         if (q0.size() == 0) ready_err++;
         else begin
            it = q0.pop_front();
            if (!it.last) gap0 = gap_len0;
         end
      end
      if (bus.s1_ready) begin
         if (q1.size() == 0) ready_err++;
         else begin
            it = q1.pop_front();
            if (!it.last) gap1 = gap_len1;
         end
      end
      if (bus.tx_start) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      bus.tx_busy  = busy_hold || (busy_cnt > 0);
      bus.s0_valid = (q0.size() > 0) && (gap0 == 0);
      bus.s1_valid = (q1.size() > 0) && (gap1 == 0);
      if (q0.size() > 0) begin bus.s0_data = q0[0].data; bus.s0_last = q0[0].last; end
      if (q1.size() > 0) begin bus.s1_data = q1[0].data; bus.s1_last = q1[0].last; end
   endtask

   // Frame-level reference: whole frames, round robin among sources that still have frames queued.
   task automatic model_frames(input item_t a0[$], input item_t a1[$]);
      int i0, i1;
      bit have0, have1, src;
      logic [7:0] sum;
      item_t it;
      i0 = 0;
      i1 = 0;
      while (i0 < a0.size() || i1 < a1.size()) begin
         have0 = i0 < a0.size();
         have1 = i1 < a1.size();
         src = (have0 && have1) ? !rr_last : have1;
         rr_last = src;
         sum = src ? ID1 : ID0;
         exp_q.push_back(SOF);
         exp_q.push_back(sum);
         do begin
            it = src ? a1[i1] : a0[i0];
            if (src) i1++; else i0++;
            exp_q.push_back(it.data);
            sum ^= it.data;
         end while (!it.last && (src ? (i1 < a1.size()) : (i0 < a0.size())));
         if (CS_EN) exp_q.push_back(sum);
      end
   endtask

   task automatic begin_scn();
      got.delete();
      start_cyc.delete();
      exp_q.delete();
      pulse_err = 0; busy_err = 0; ready_err = 0; stab_err = 0; gap_err = 0; idle_err = 0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && bus.grant == 2'b00 && busy_cnt == 0) && n < 20000) begin
         step();
         n++;
      end
      check({name, " finished within budget"}, 32'(n < 20000), 32'(1));
      repeat (3) step();
   endtask

   task automatic end_scn(input string name);
      check({name, " byte count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s byte %0d", name, i), got_at(i), 32'(exp_q[i]));
      check({name, " tx_start pulse width"}, 32'(pulse_err), 32'(0));
      check({name, " tx_start while busy"}, 32'(busy_err), 32'(0));
      check({name, " ready protocol"}, 32'(ready_err), 32'(0));
      check({name, " tx_data stable"}, 32'(stab_err), 32'(0));
      check({name, " tx_start in valid gap"}, 32'(gap_err), 32'(0));
      check({name, " idle between frames"}, 32'(idle_err), 32'(0));
      check({name, " grant idle at end"}, 32'(bus.grant), 32'(0));
      check({name, " frame_active low at end"}, 32'(bus.frame_active), 32'(0));
   endtask

   initial begin
      vec_t  vecs[5];
      item_t a0[$], a1[$];
      int    n, v_cyc, nf0, nf1, len, fl1, fl2;

      vecs[0] = '{src: 1'b0, len: 3'd2, pay: {8'h00, 8'h00, 8'h34, 8'h12}, exp_len: 3'd4,
                  exp: {8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'hAA}, cs: 8'h26};
      vecs[1] = '{src: 1'b1, len: 3'd1, pay: {8'h00, 8'h00, 8'h00, 8'hFF}, exp_len: 3'd3,
                  exp: {8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'hAA}, cs: 8'hFE};
      vecs[2] = '{src: 1'b0, len: 3'd1, pay: {8'h00, 8'h00, 8'h00, 8'h00}, exp_len: 3'd3,
                  exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA}, cs: 8'h00};
      vecs[3] = '{src: 1'b1, len: 3'd4, pay: {8'h04, 8'h03, 8'h02, 8'h01}, exp_len: 3'd6,
                  exp: {8'h04, 8'h03, 8'h02, 8'h01, 8'h01, 8'hAA}, cs: 8'h05};
      vecs[4] = '{src: 1'b0, len: 3'd3, pay: {8'h00, 8'h0F, 8'h55, 8'hAA}, exp_len: 3'd5,
                  exp: {8'h00, 8'h0F, 8'h55, 8'hAA, 8'h00, 8'hAA}, cs: 8'hF0};

      reset_n = 1'b0;
      bus.s0_valid = 1'b0; bus.s0_data = 8'h00; bus.s0_last = 1'b0;
      bus.s1_valid = 1'b0; bus.s1_data = 8'h00; bus.s1_last = 1'b0;
      bus.tx_busy  = 1'b0;
      begin_scn();
      repeat (3) step();
      check("reset tx_start", 32'(bus.tx_start), 32'(0));
      check("reset s0_ready", 32'(bus.s0_ready), 32'(0));
      check("reset s1_ready", 32'(bus.s1_ready), 32'(0));
      check("reset grant", 32'(bus.grant), 32'(0));
      check("reset frame_active", 32'(bus.frame_active), 32'(0));
      check("reset tx_data", 32'(bus.tx_data), 32'(0));
      reset_n = 1'b1;
      step();

      // Valid in IDLE at cycle t gives the SOF strobe at t+2 with the transmitter free.
      begin_scn();
      a0.delete(); a1.delete();
      a0.push_back('{data: 8'h77, last: 1'b1});
      model_frames(a0, a1);
      q0 = a0;
      step();
      v_cyc = cyc;
      check("latency valid driven", 32'(bus.s0_valid), 32'(1));
      n = 0;
      while (got.size() == 0 && n < 50) begin step(); n++; end
      check("latency to first tx_start", 32'(last_start_cyc - v_cyc), 32'(2));
      wait_done("latency");
      end_scn("latency");

      for (int v = 0; v < 5; v++) begin
         begin_scn();
         busy_len = 10;
         for (int i = 0; i < int'(vecs[v].len); i++) begin
            if (vecs[v].src) q1.push_back('{data: vecs[v].pay[i], last: (i == int'(vecs[v].len) - 1)});
            else             q0.push_back('{data: vecs[v].pay[i], last: (i == int'(vecs[v].len) - 1)});
         end
         for (int i = 0; i < int'(vecs[v].exp_len); i++) exp_q.push_back(vecs[v].exp[i]);
         if (CS_EN) exp_q.push_back(vecs[v].cs);
         rr_last = vecs[v].src;
         wait_done($sformatf("vec%0d", v));
         end_scn($sformatf("vec%0d", v));
      end

      // Requester 1 drops valid for 20 cycles after its first payload byte.
      begin_scn();
      gap_len1 = 20;
      a0.delete(); a1.delete();
      a1.push_back('{data: 8'h10, last: 1'b0});
      a1.push_back('{data: 8'h20, last: 1'b0});
      a1.push_back('{data: 8'h30, last: 1'b1});
      model_frames(a0, a1);
      q1 = a1;
      wait_done("gap");
      check("gap stall length", 32'((start_cyc.size() > 3) && (start_cyc[3] - start_cyc[2] >= 21)), 32'(1));
      end_scn("gap");
      gap_len1 = 0;

      // Transmitter busy for 50 cycles while SOF is pending.
      begin_scn();
      busy_hold = 1'b1;
      step();
      a0.delete(); a1.delete();
      a0.push_back('{data: 8'h5A, last: 1'b1});
      model_frames(a0, a1);
      q0 = a0;
      repeat (50) step();
      check("busy hold no tx_start", 32'(got.size()), 32'(0));
      check("busy hold grant", 32'(bus.grant), 32'(2'b01));
      busy_hold = 1'b0;
      wait_done("busy hold");
      end_scn("busy hold");

      // Reset mid-payload abandons the frame.
      begin_scn();
      q0.push_back('{data: 8'hC1, last: 1'b0});
      q0.push_back('{data: 8'hC2, last: 1'b0});
      q0.push_back('{data: 8'hC3, last: 1'b1});
      n = 0;
      while (got.size() < 3 && n < 2000) begin step(); n++; end
      check("reset test reached payload", got_at(2), 32'(8'hC1));
      reset_n = 1'b0;
      #1;
      check("async reset tx_start", 32'(bus.tx_start), 32'(0));
      check("async reset s0_ready", 32'(bus.s0_ready), 32'(0));
      check("async reset grant", 32'(bus.grant), 32'(0));
      check("async reset frame_active", 32'(bus.frame_active), 32'(0));
      check("async reset tx_data", 32'(bus.tx_data), 32'(0));
      q0.delete();
      busy_cnt = 0; gap0 = 0; gap1 = 0;
      bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; bus.tx_busy = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      rr_last = 1'b1;
      n = got.size();
      repeat (40) step();
      check("no residual bytes after reset", 32'(got.size()), 32'(n));
      check("idle after reset", 32'(bus.grant), 32'(0));

      // Simultaneous requests after reset: s0, s1, then s0 wins the next tie.
      begin_scn();
      a0.delete(); a1.delete();
      a0.push_back('{data: 8'h11, last: 1'b0});
      a0.push_back('{data: 8'h22, last: 1'b1});
      a0.push_back('{data: 8'h44, last: 1'b1});
      a1.push_back('{data: 8'h33, last: 1'b1});
      a1.push_back('{data: 8'h55, last: 1'b1});
      model_frames(a0, a1);
      q0 = a0;
      q1 = a1;
      wait_done("tie");
      fl1 = CS_EN ? 5 : 4;
      fl2 = CS_EN ? 4 : 3;
      check("tie frame1 ID", got_at(1), 32'(8'h00));
      check("tie frame2 ID", got_at(fl1 + 1), 32'(8'h01));
      check("tie frame3 ID", got_at(fl1 + fl2 + 1), 32'(8'h00));
      check("tie frame4 ID", got_at(fl1 + 2 * fl2 + 1), 32'(8'h01));
      end_scn("tie");

      for (int r = 0; r < 12; r++) begin
         begin_scn();
         a0.delete(); a1.delete();
         nf0 = $urandom_range(3, 0);
         nf1 = $urandom_range(3, 0);
         if (nf0 + nf1 == 0) nf0 = 1;
         for (int f = 0; f < nf0; f++) begin
            len = $urandom_range(4, 1);
            for (int k = 0; k < len; k++) a0.push_back('{data: 8'($urandom), last: (k == len - 1)});
         end
         for (int f = 0; f < nf1; f++) begin
            len = $urandom_range(4, 1);
            for (int k = 0; k < len; k++) a1.push_back('{data: 8'($urandom), last: (k == len - 1)});
         end
         busy_len = $urandom_range(12, 1);
         gap_len0 = $urandom_range(5, 0);
         gap_len1 = $urandom_range(5, 0);
         model_frames(a0, a1);
         q0 = a0;
         q1 = a1;
         wait_done($sformatf("rand%0d", r));
         end_scn($sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
